if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the pipelined MIPS core. It holds the PC and drives the instruction-memory address. It loads the IF/ID pipeline register. It consumes the word-aligned branch offset produced by the shift-left-2 unit, adds it to the branch's PC+4 to form the branch target, and handles jump redirects, stalls and flushes from the hazard/branch logic.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0000, instruction word written into IF/ID on flush/reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hazard unit: hold PC and IF/ID this cycle
branch_taken  in  1  branch resolved taken this cycle (from ID)
branch_offset_sh  in  32  sign-extended offset already shifted left by 2
redir_pc4  in  32  PC+4 of the branch/jump instruction in ID
jump  in  1  unconditional jump resolved this cycle (from ID)
jump_index  in  26  instr[25:0] of the jump
imem_addr  out  32  instruction memory address (combinational = pc)
imem_rdata  in  32  instruction word at imem_addr (combinational read)
pc  out  32  current PC register
if_id_inst  out  32  IF/ID instruction register
if_id_pc4  out  32  IF/ID PC+4 register
if_id_valid  out  1  IF/ID holds a real instruction
fetch_count  out  32  count of instructions loaded into IF/ID

Behaviour:
- One clock (clk); rst synchronous, active-high. It has priority over every other input.
- Reset values: pc=RESET_PC, if_id_inst=NOP_INST, if_id_pc4=0, if_id_valid=0, fetch_count=0.
- imem_addr = pc, combinational, no latency. Instruction is captured into IF/ID at the edge ending the fetch cycle (1-cycle fetch latency).
- pc4 = pc + 32'd4, modulo 2^32. PC wraps from 32'hFFFF_FFFC to 0.
- branch_target = redir_pc4 + branch_offset_sh, modulo 2^32. Bits [1:0] are forced to 2'b00.
- jump_target = {redir_pc4[31:28], jump_index, 2'b00}.
- Next-PC priority, evaluated every cycle:
  1. rst: RESET_PC
  2. jump: jump_target
  3. branch_taken: branch_target
  4. stall: pc (hold)
  5. else: pc4
- jump and branch_taken both asserted: jump wins, and the branch is ignored.
- IF/ID update, same priority order:
  - rst: reset values.
  - jump or branch_taken (redirect): flush. Set if_id_inst=NOP_INST, if_id_pc4=0 and if_id_valid=0. This happens even if stall=1, because a redirect overrides stall.
  - stall: hold all IF/ID registers.
  - else: load if_id_inst=imem_rdata, if_id_pc4=pc4, if_id_valid=1.
- fetch_count increments by 1 exactly on cycles where IF/ID loads (case "else" above). It wraps 32'hFFFF_FFFF to 0. Reset clears it.
- Reset mid-stream: any stall/redirect in the same cycle is ignored. The first fetch after rst deasserts is from RESET_PC.
- Stall held N cycles: pc, imem_addr and IF/ID stay constant for N cycles, and fetch_count stays unchanged.
- Negative offsets: branch_offset_sh is treated as two's complement via plain 32-bit addition, with no overflow flag.

Test Plan:
- Reset then run, RESET_PC=0: rst high 2 cycles, then low; imem returns 32'h1111_0000+addr → pc goes 0,4,8,C. The cycle after each fetch, if_id_inst=32'h1111_0000/…0004/…0008, if_id_pc4=4/8/C, if_id_valid=1, and fetch_count=1,2,3.
- Stall: at pc=8 assert stall 3 cycles → pc stays 8, IF/ID holds inst@4 and pc4=8, fetch_count stays constant. Release → pc=C next edge.
- Forward and backward branch: branch_taken=1, redir_pc4=32'h0000_0010, offset=32'h0000_0020 → pc=32'h30 and IF/ID flushed (valid=0, inst=NOP). With offset=32'hFFFF_FFF0 → pc=0.
- Jump vs branch and vs stall: jump=1, branch_taken=1, stall=1, redir_pc4=32'hA000_0004, jump_index=26'h0000100 → pc=32'hA000_0400, IF/ID flushed, fetch_count unchanged.
- Wrap: force pc to 32'hFFFF_FFFC via branch (redir_pc4=0, offset=32'hFFFF_FFFC). Next normal cycle → pc=0 and if_id_pc4=0.
- Reset mid-operation: rst asserted together with branch_taken at pc=32'h40 → pc=RESET_PC, all IF/ID outputs and fetch_count equal their reset values.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (jump/branch/stall),
// and the IF/ID pipeline register with flush-on-redirect and fetch counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset_sh,
  input  logic [31:0] redir_pc4,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic            load;

  assign imem_addr = pc;

  // Target arithmetic; all sums wrap modulo 2^32, branch target kept word-aligned.
  always_comb begin
    pc4           = pc + XLEN'(4);
    branch_target = (redir_pc4 + branch_offset_sh) & ~XLEN'(3);
    jump_target   = {redir_pc4[31:28], jump_index, 2'b00};
  end

  // Next-PC selection: jump beats branch, any redirect beats stall.
  always_comb begin
    next_pc  = pc4;
    redirect = jump | branch_taken;
    load     = 1'b0;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else if (stall) begin
      next_pc = pc;
    end else begin
      load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_id_inst  <= NOP_INST;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc <= next_pc;
      if (redirect) begin
        if_id_inst  <= NOP_INST;
        if_id_pc4   <= '0;
        if_id_valid <= 1'b0;
      end else if (load) begin
        if_id_inst  <= imem_rdata;
        if_id_pc4   <= pc4;
        if_id_valid <= 1'b1;
        fetch_count <= fetch_count + XLEN'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; imem returns 32'h1111_0000 + addr.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset_sh;
  logic [31:0] redir_pc4;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int passed = 0;
  int total  = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_offset_sh(branch_offset_sh), .redir_pc4(redir_pc4), .jump(jump),
    .jump_index(jump_index), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc(pc), .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_rdata = 32'h1111_0000 + imem_addr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_offset_sh = '0; redir_pc4 = '0; jump_index = '0;
    step(); step();
    total++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want %h", pc, 32'h0); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL reset_imem_addr got %h want %h", imem_addr, 32'h0); else passed++;
    total++; if (if_id_inst !== 32'h0) $display("FAIL reset_inst got %h want %h", if_id_inst, 32'h0); else passed++;
    total++; if (if_id_pc4 !== 32'h0) $display("FAIL reset_pc4 got %h want %h", if_id_pc4, 32'h0); else passed++;
    total++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", if_id_valid); else passed++;
    total++; if (fetch_count !== 32'h0) $display("FAIL reset_count got %0d want 0", fetch_count); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_run();
    for (int i = 1; i <= 2; i++) begin
      step();
      total++; if (pc !== 32'(4 * i)) $display("FAIL run_pc[%0d] got %h want %h", i, pc, 32'(4 * i)); else passed++;
      total++;
      if ({if_id_inst, if_id_pc4, if_id_valid} !== {32'h1111_0000 + 32'(4 * (i - 1)), 32'(4 * i), 1'b1})
        $display("FAIL run_ifid[%0d] got %h/%h/%b want %h/%h/1", i, if_id_inst, if_id_pc4, if_id_valid,
                 32'h1111_0000 + 32'(4 * (i - 1)), 32'(4 * i));
      else passed++;
      total++; if (fetch_count !== 32'(i)) $display("FAIL run_count[%0d] got %0d want %0d", i, fetch_count, i); else passed++;
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({pc, imem_addr} !== {32'h8, 32'h8})
        $display("FAIL stall_pc[%0d] got %h/%h want 8/8", i, pc, imem_addr);
      else passed++;
      total++;
      if ({if_id_inst, if_id_pc4, if_id_valid, fetch_count} !== {32'h1111_0004, 32'h8, 1'b1, 32'd2})
        $display("FAIL stall_hold[%0d] got %h/%h/%b/%0d want 11110004/8/1/2", i, if_id_inst, if_id_pc4,
                 if_id_valid, fetch_count);
      else passed++;
    end
    stall = 1'b0;
    step();
    total++; if (pc !== 32'hC) $display("FAIL stall_release_pc got %h want c", pc); else passed++;
    total++;
    if ({if_id_inst, if_id_pc4, fetch_count} !== {32'h1111_0008, 32'hC, 32'd3})
      $display("FAIL stall_release_ifid got %h/%h/%0d want 11110008/c/3", if_id_inst, if_id_pc4, fetch_count);
    else passed++;
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; redir_pc4 = 32'h10; branch_offset_sh = 32'h20;
    step();
    total++; if (pc !== 32'h30) $display("FAIL br_fwd_pc got %h want 30", pc); else passed++;
    total++;
    if ({if_id_inst, if_id_pc4, if_id_valid, fetch_count} !== {32'h0, 32'h0, 1'b0, 32'd3})
      $display("FAIL br_flush got %h/%h/%b/%0d want 0/0/0/3", if_id_inst, if_id_pc4, if_id_valid, fetch_count);
    else passed++;
    branch_offset_sh = 32'hFFFF_FFF0;
    step();
    total++; if (pc !== 32'h0) $display("FAIL br_back_pc got %h want 0", pc); else passed++;
    branch_offset_sh = 32'h23;
    step();
    total++; if (pc !== 32'h30) $display("FAIL br_align_pc got %h want 30", pc); else passed++;
    branch_taken = 1'b0;
    step();
    total++; if (pc !== 32'h34) $display("FAIL br_resume_pc got %h want 34", pc); else passed++;
    total++;
    if ({if_id_inst, if_id_pc4, if_id_valid, fetch_count} !== {32'h1111_0030, 32'h34, 1'b1, 32'd4})
      $display("FAIL br_resume_ifid got %h/%h/%b/%0d want 11110030/34/1/4", if_id_inst, if_id_pc4,
               if_id_valid, fetch_count);
    else passed++;
  endtask

  task automatic test_jump();
    jump = 1'b1; branch_taken = 1'b1; stall = 1'b1;
    redir_pc4 = 32'hA000_0004; jump_index = 26'h0000100; branch_offset_sh = 32'h20;
    step();
    total++; if (pc !== 32'hA000_0400) $display("FAIL jump_pc got %h want a0000400", pc); else passed++;
    total++;
    if ({if_id_inst, if_id_pc4, if_id_valid, fetch_count} !== {32'h0, 32'h0, 1'b0, 32'd4})
      $display("FAIL jump_flush got %h/%h/%b/%0d want 0/0/0/4", if_id_inst, if_id_pc4, if_id_valid, fetch_count);
    else passed++;
    jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; redir_pc4 = 32'h0; branch_offset_sh = 32'hFFFF_FFFC;
    step();
    total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pre_pc got %h want fffffffc", pc); else passed++;
    branch_taken = 1'b0;
    step();
    total++; if (pc !== 32'h0) $display("FAIL wrap_pc got %h want 0", pc); else passed++;
    total++;
    if ({if_id_inst, if_id_pc4, if_id_valid, fetch_count} !== {32'h1110_FFFC, 32'h0, 1'b1, 32'd5})
      $display("FAIL wrap_ifid got %h/%h/%b/%0d want 1110fffc/0/1/5", if_id_inst, if_id_pc4, if_id_valid,
               fetch_count);
    else passed++;
  endtask

  task automatic test_reset_mid();
    branch_taken = 1'b1; redir_pc4 = 32'h3C; branch_offset_sh = 32'h0;
    step();
    branch_taken = 1'b0;
    step();
    total++; if ({pc, fetch_count} !== {32'h40, 32'd6}) $display("FAIL mid_setup got %h/%0d want 40/6", pc, fetch_count); else passed++;
    rst = 1'b1; branch_taken = 1'b1; stall = 1'b1; redir_pc4 = 32'h100;
    step();
    total++; if (pc !== 32'h0) $display("FAIL mid_reset_pc got %h want 0", pc); else passed++;
    total++;
    if ({if_id_inst, if_id_pc4, if_id_valid, fetch_count} !== {32'h0, 32'h0, 1'b0, 32'd0})
      $display("FAIL mid_reset_state got %h/%h/%b/%0d want 0/0/0/0", if_id_inst, if_id_pc4, if_id_valid,
               fetch_count);
    else passed++;
    rst = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    step();
    total++;
    if ({pc, if_id_inst, if_id_pc4, if_id_valid, fetch_count} !== {32'h4, 32'h1111_0000, 32'h4, 1'b1, 32'd1})
      $display("FAIL post_reset_fetch got %h/%h/%h/%b/%0d want 4/11110000/4/1/1", pc, if_id_inst, if_id_pc4,
               if_id_valid, fetch_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_branch();
    test_jump();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
